exe_div_unit: RTL and testbench

EXE_DIV_UNIT -- requirements
Module: exe_div_unit

---
 rtl/exe_div_unit_pkg.sv | 20 ++
 rtl/exe_div_unit_if.sv | 25 ++
 rtl/exe_div_unit_div_step.sv | 23 ++
 rtl/exe_div_unit.sv | 125 ++++++++++++
 tb/tb_exe_div_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/exe_div_unit_pkg.sv
// Shared encodings and widths for the E-stage iterative divider.
// Imported by the interface, the FSM top and the step datapath.
package exe_div_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    // isDivE encodings; 2'b11 is treated the same as DIV_NONE
    localparam logic [1:0] DIV_NONE     = 2'b00;
    localparam logic [1:0] DIV_SIGNED   = 2'b01;
    localparam logic [1:0] DIV_UNSIGNED = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } divState_t;

endpackage

// File: rtl/exe_div_unit_if.sv
// E-stage <-> divider signal bundle; master is the pipeline side, slave is the divider.
interface exe_div_unit_if;
    import exe_div_unit_pkg::*;

    logic [1:0]        isDivE;
    logic [DATA_W-1:0] SrcAE;
    logic [DATA_W-1:0] SrcBE;
    logic              ExtStallE;
    logic              CancelE;
    logic              DivStallE;
    logic              DivDoneE;
    logic [DATA_W-1:0] HiResultE;
    logic [DATA_W-1:0] LoResultE;

    modport master (
        output isDivE, SrcAE, SrcBE, ExtStallE, CancelE,
        input  DivStallE, DivDoneE, HiResultE, LoResultE
    );

    modport slave (
        input  isDivE, SrcAE, SrcBE, ExtStallE, CancelE,
        output DivStallE, DivDoneE, HiResultE, LoResultE
    );

endinterface

// File: rtl/exe_div_unit_div_step.sv
// One restoring shift-subtract iteration on a {remainder, quotient} accumulator.
// The dividend is shifted in from the low half while quotient bits fill in behind it.
module div_step
    import exe_div_unit_pkg::*;
(
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W-1:0] accNext
);

    logic [DATA_W:0]   hiShift;
    logic [DATA_W-1:0] remNext;
    logic              geq;

    // The shifted remainder needs one extra bit before the trial subtraction
    always_comb begin
        hiShift = acc[2*DATA_W-1:DATA_W-1];
        geq     = hiShift >= {1'b0, divisor};
        remNext = geq ? (hiShift[DATA_W-1:0] - divisor) : hiShift[DATA_W-1:0];
        accNext = {remNext, acc[DATA_W-2:0], geq};
    end

endmodule

// File: rtl/exe_div_unit.sv
// Multi-cycle signed/unsigned 32-bit divider for the E stage: 34-cycle stall,
// magnitude restoring division, then a sign fixup cycle before results are presented.
module exe_div_unit
    import exe_div_unit_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    exe_div_unit_if.slave  bus
);

    divState_t                state, stateNext;
    logic [CNT_W-1:0]         cnt;
    logic [2*DATA_W-1:0]      acc, accNext;
    logic [DATA_W-1:0]        divisorMag, dividendRaw;
    logic [DATA_W-1:0]        hiRes, loRes, hiFix, loFix;
    logic [DATA_W-1:0]        magA, magB;
    logic                     qNeg, rNeg, divZero;
    logic                     isSigned, reqValid, startDiv;
    logic signed [DATA_W-1:0] srcASgn, srcBSgn;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    always_comb begin
        isSigned = bus.isDivE == DIV_SIGNED;
        reqValid = (bus.isDivE == DIV_SIGNED) || (bus.isDivE == DIV_UNSIGNED);
        srcASgn  = bus.SrcAE;
        srcBSgn  = bus.SrcBE;
        // 0x80000000 negates to itself, which is the correct unsigned magnitude
        magA     = (isSigned && srcASgn < 0) ? negate(bus.SrcAE) : bus.SrcAE;
        magB     = (isSigned && srcBSgn < 0) ? negate(bus.SrcBE) : bus.SrcBE;
    end

    div_step uStep (
        .acc     (acc),
        .divisor (divisorMag),
        .accNext (accNext)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (bus.CancelE) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (reqValid) stateNext = BUSY;
                BUSY:    if (cnt == CNT_W'(DATA_W-1)) stateNext = SIGN;
                SIGN:    stateNext = DONE;
                DONE:    if (!bus.ExtStallE) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Stall is combinational so the hazard unit holds E in the detect cycle itself
    always_comb begin
        startDiv      = 1'b0;
        bus.DivStallE = 1'b0;
        bus.DivDoneE  = 1'b0;
        if (reset && !bus.CancelE) begin
            case (state)
                IDLE: begin
                    startDiv      = reqValid;
                    bus.DivStallE = reqValid;
                end
                BUSY, SIGN: bus.DivStallE = 1'b1;
                DONE:       bus.DivDoneE  = 1'b1;
                default: ;
            endcase
        end
    end

    // Divide-by-zero skips sign fixup: all-ones quotient and the raw dividend
    always_comb begin
        if (divZero) begin
            loFix = '1;
            hiFix = dividendRaw;
        end else begin
            loFix = qNeg ? negate(acc[DATA_W-1:0]) : acc[DATA_W-1:0];
            hiFix = rNeg ? negate(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            acc         <= '0;
            divisorMag  <= '0;
            dividendRaw <= '0;
            qNeg        <= 1'b0;
            rNeg        <= 1'b0;
            divZero     <= 1'b0;
            hiRes       <= '0;
            loRes       <= '0;
        end else begin
            if (startDiv) begin
                acc         <= {{DATA_W{1'b0}}, magA};
                divisorMag  <= magB;
                dividendRaw <= bus.SrcAE;
                qNeg        <= isSigned && (bus.SrcAE[DATA_W-1] ^ bus.SrcBE[DATA_W-1]);
                rNeg        <= isSigned && bus.SrcAE[DATA_W-1];
                divZero     <= bus.SrcBE == '0;
                cnt         <= '0;
            end else if (state == BUSY && !bus.CancelE) begin
                acc <= accNext;
                cnt <= cnt + CNT_W'(1);
            end
            // Result registers only move on a completed, uncancelled SIGN cycle
            if (state == SIGN && !bus.CancelE) begin
                hiRes <= hiFix;
                loRes <= loFix;
            end
        end
    end

    assign bus.HiResultE = hiRes;
    assign bus.LoResultE = loRes;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed bench for exe_div_unit: vector table of divides plus hand-written
// cancel, external-stall and mid-division reset sequences.
module tb_exe_div_unit;
    import exe_div_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    exe_div_unit_if bus();

    exe_div_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expLo;
        logic [31:0] expHi;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one divide, count stall cycles, check results, hold DONE for extHold cycles
    task automatic doDiv(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expLo,
                         input logic [31:0] expHi, input int extHold);
        int stalls;
        bit done;
        @(posedge clock);
        #1;
        bus.isDivE = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (bus.DivDoneE) done = 1'b1;
            else if (bus.DivStallE) stalls++;
        end
        check({nm, " done reached"}, 32'(done), 32'd1);
        check({nm, " stall cycles"}, 32'(stalls), 32'd34);
        check({nm, " lo"}, bus.LoResultE, expLo);
        check({nm, " hi"}, bus.HiResultE, expHi);
        check({nm, " stall in done"}, 32'(bus.DivStallE), 32'd0);
        for (int k = 1; k < extHold; k++) begin
            bus.ExtStallE = 1'b1;
            @(negedge clock);
            check({nm, " done held"}, 32'(bus.DivDoneE), 32'd1);
            check({nm, " no restart"}, 32'(bus.DivStallE), 32'd0);
            check({nm, " lo held"}, bus.LoResultE, expLo);
        end
        bus.ExtStallE = 1'b0;
        @(posedge clock);
        #1;
        bus.isDivE = DIV_NONE;
        @(negedge clock);
        check({nm, " idle done"}, 32'(bus.DivDoneE), 32'd0);
        check({nm, " idle stall"}, 32'(bus.DivStallE), 32'd0);
        check({nm, " idle lo kept"}, bus.LoResultE, expLo);
    endtask

    initial begin
        bit sawDone, sawStall;
        vecs[0] = '{"divu 100/7",        DIV_UNSIGNED, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{"div -7/2",          DIV_SIGNED,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2] = '{"div min/-1",        DIV_SIGNED,   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[3] = '{"divu 5/0",          DIV_UNSIGNED, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
        vecs[4] = '{"div 7/-2",          DIV_SIGNED,   32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[5] = '{"div -7/0",          DIV_SIGNED,   32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9};
        vecs[6] = '{"divu max/1",        DIV_UNSIGNED, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[7] = '{"divu 0x8000_0000/max", DIV_UNSIGNED, 32'h80000000, 32'hFFFFFFFF,  32'd0,          32'h80000000};
        vecs[8] = '{"div -100/-7",       DIV_SIGNED,   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};

        bus.isDivE    = DIV_NONE;
        bus.SrcAE     = '0;
        bus.SrcBE     = '0;
        bus.ExtStallE = 1'b0;
        bus.CancelE   = 1'b0;

        repeat (2) @(negedge clock);
        check("reset stall", 32'(bus.DivStallE), 32'd0);
        check("reset done", 32'(bus.DivDoneE), 32'd0);
        check("reset hi", bus.HiResultE, 32'd0);
        check("reset lo", bus.LoResultE, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Encoding 11 must not start a divide
        @(posedge clock);
        #1;
        bus.isDivE = 2'b11;
        bus.SrcAE  = 32'd10;
        bus.SrcBE  = 32'd3;
        @(negedge clock);
        check("op11 stall", 32'(bus.DivStallE), 32'd0);
        @(negedge clock);
        check("op11 stays idle", 32'(bus.DivStallE), 32'd0);
        bus.isDivE = DIV_NONE;

        for (int i = 0; i < 9; i++)
            doDiv(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expLo, vecs[i].expHi, 1);

        doDiv("divu 50/5 ext stall", DIV_UNSIGNED, 32'd50, 32'd5, 32'd10, 32'd0, 3);

        // Cancel during BUSY cycle 10
        @(posedge clock);
        #1;
        bus.isDivE = DIV_UNSIGNED;
        bus.SrcAE  = 32'd100;
        bus.SrcBE  = 32'd7;
        @(negedge clock);
        check("cancel detect stall", 32'(bus.DivStallE), 32'd1);
        repeat (10) @(posedge clock);
        #1;
        bus.CancelE = 1'b1;
        @(negedge clock);
        check("cancel stall dropped", 32'(bus.DivStallE), 32'd0);
        @(posedge clock);
        #1;
        bus.CancelE = 1'b0;
        bus.isDivE  = DIV_NONE;
        sawDone  = 1'b0;
        sawStall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.DivDoneE) sawDone = 1'b1;
            if (bus.DivStallE) sawStall = 1'b1;
        end
        check("cancel no done", 32'(sawDone), 32'd0);
        check("cancel idle", 32'(sawStall), 32'd0);
        check("cancel lo discarded", bus.LoResultE, 32'd10);

        // Reset mid-BUSY
        @(posedge clock);
        #1;
        bus.isDivE = DIV_UNSIGNED;
        bus.SrcAE  = 32'd100;
        bus.SrcBE  = 32'd7;
        @(negedge clock);
        check("rst detect stall", 32'(bus.DivStallE), 32'd1);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst mid stall", 32'(bus.DivStallE), 32'd0);
        check("rst mid done", 32'(bus.DivDoneE), 32'd0);
        check("rst mid hi", bus.HiResultE, 32'd0);
        check("rst mid lo", bus.LoResultE, 32'd0);
        bus.isDivE = DIV_NONE;
        @(posedge clock);
        #1;
        reset = 1'b1;
        doDiv("divu 9/3 after reset", DIV_UNSIGNED, 32'd9, 32'd3, 32'd3, 32'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
